// File: rtl/tlb_probe_read_pkg.sv
`default_nettype none
// tlb_probe_read_pkg - shared TLB op codes, entry field slices and FSM states for the TLB read side.
// Rev 1.0
package tlb_probe_read_pkg;

    localparam int TLB_ENTRIES = 16;
    localparam int TLB_IDX_W   = 4;
    localparam int TLB_ENTRY_W = 96;

    localparam logic [1:0] TLB_OP_PROBE = 2'b01;
    localparam logic [1:0] TLB_OP_READ  = 2'b10;

    // Entry layout {EntryHi[95:64], EntryLo0[63:32], EntryLo1[31:0]}
    localparam int VPN2_HI = 95;
    localparam int VPN2_LO = 77;
    localparam int VPN2_W  = VPN2_HI - VPN2_LO + 1;
    localparam int ASID_HI = 71;
    localparam int ASID_LO = 64;
    localparam int ASID_W  = ASID_HI - ASID_LO + 1;
    localparam int G_BIT   = 0;

    // Same fields as they sit in the CP0 EntryHi register
    localparam int EHI_VPN2_LO = 13;
    localparam int EHI_ASID_HI = 7;

    localparam logic [31:0] PROBE_MISS = 32'h8000_0000;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_PROBE = 2'd1,
        ST_READ  = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

endpackage
`default_nettype wire

// File: rtl/tlb_probe_read_entry_match.sv
`default_nettype none
// tlb_entry_match - combinational VPN2 + ASID/global match of one TLB entry.
// Rev 1.0
module tlb_entry_match
    import tlb_probe_read_pkg::*;
(
    input  logic [TLB_ENTRY_W-1:0] entry,
    input  logic [VPN2_W-1:0]      vpn2,
    input  logic [ASID_W-1:0]      asid,
    output logic                   hit
);

    logic unused_fields;

    assign unused_fields = ^{entry[VPN2_LO-1:ASID_HI+1], entry[ASID_LO-1:G_BIT+1]};

    assign hit = (entry[VPN2_HI:VPN2_LO] == vpn2) &&
                 ((entry[ASID_HI:ASID_LO] == asid) || entry[G_BIT]);

endmodule
`default_nettype wire

// File: rtl/tlb_probe_read.sv
`default_nettype none
// tlb_probe_read - TLBP/TLBR engine on the TLB read port; probe scans one entry per clock.
// Rev 1.0
module tlb_probe_read
    import tlb_probe_read_pkg::*;
#(
    parameter int ENTRIES = TLB_ENTRIES,
    parameter int IDX_W   = TLB_IDX_W,
    parameter int ENTRY_W = TLB_ENTRY_W
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               op_valid_i,
    input  logic [1:0]         op_i,
    input  logic [31:0]        index_i,
    input  logic [31:0]        entryhi_i,
    output logic [IDX_W-1:0]   tlb_rd_idx_o,
    input  logic [ENTRY_W-1:0] tlb_rd_entry_i,
    output logic               stall_req_o,
    output logic               done_o,
    output logic               index_we_o,
    output logic [31:0]        index_o,
    output logic               entry_we_o,
    output logic [31:0]        entryhi_o,
    output logic [31:0]        entrylo0_o,
    output logic [31:0]        entrylo1_o
);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(ENTRIES - 1);

    state_t            state;
    state_t            state_nxt;
    logic [IDX_W-1:0]  counter;
    logic [IDX_W-1:0]  rd_idx;
    logic [VPN2_W-1:0] vpn2;
    logic [ASID_W-1:0] asid;
    logic              is_read;
    logic              hit;
    logic              accept_probe;
    logic              accept_read;
    logic [31:0]       res_index;
    logic [31:0]       res_hi;
    logic [31:0]       res_lo0;
    logic [31:0]       res_lo1;
    logic              unused_inputs;

    assign unused_inputs = ^{index_i[31:IDX_W], entryhi_i[EHI_VPN2_LO-1:EHI_ASID_HI+1]};

    assign accept_probe = (state == ST_IDLE) && op_valid_i && (op_i == TLB_OP_PROBE);
    assign accept_read  = (state == ST_IDLE) && op_valid_i && (op_i == TLB_OP_READ);

    tlb_entry_match u_match (
        .entry (tlb_rd_entry_i),
        .vpn2  (vpn2),
        .asid  (asid),
        .hit   (hit)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt    = state;
        stall_req_o  = 1'b0;
        done_o       = 1'b0;
        index_we_o   = 1'b0;
        entry_we_o   = 1'b0;
        tlb_rd_idx_o = '0;
        case (state)
            ST_IDLE: begin
                if (accept_probe) begin
                    stall_req_o = 1'b1;
                    state_nxt   = ST_PROBE;
                end else if (accept_read) begin
                    stall_req_o = 1'b1;
                    state_nxt   = ST_READ;
                end
            end
            ST_PROBE: begin
                stall_req_o  = 1'b1;
                tlb_rd_idx_o = counter;
                if (hit || (counter == LAST_IDX)) begin
                    state_nxt = ST_DONE;
                end
            end
            ST_READ: begin
                stall_req_o  = 1'b1;
                tlb_rd_idx_o = rd_idx;
                state_nxt    = ST_DONE;
            end
            ST_DONE: begin
                done_o     = 1'b1;
                index_we_o = !is_read;
                entry_we_o = is_read;
                state_nxt  = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Operands are latched at accept; results only change on the way into DONE.
    always_ff @(posedge clk) begin
        if (rst) begin
            counter   <= '0;
            rd_idx    <= '0;
            vpn2      <= '0;
            asid      <= '0;
            is_read   <= 1'b0;
            res_index <= '0;
            res_hi    <= '0;
            res_lo0   <= '0;
            res_lo1   <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (accept_probe) begin
                        vpn2    <= entryhi_i[31:EHI_VPN2_LO];
                        asid    <= entryhi_i[EHI_ASID_HI:0];
                        counter <= '0;
                        is_read <= 1'b0;
                    end else if (accept_read) begin
                        rd_idx  <= index_i[IDX_W-1:0];
                        is_read <= 1'b1;
                    end
                end
                ST_PROBE: begin
                    if (hit) begin
                        res_index <= {{(32-IDX_W){1'b0}}, counter};
                    end else if (counter == LAST_IDX) begin
                        res_index <= PROBE_MISS;
                    end else begin
                        counter <= counter + 1'b1;
                    end
                end
                ST_READ: begin
                    res_hi  <= tlb_rd_entry_i[95:64];
                    res_lo0 <= tlb_rd_entry_i[63:32];
                    res_lo1 <= tlb_rd_entry_i[31:0];
                end
                default: ;
            endcase
        end
    end

    assign index_o    = res_index;
    assign entryhi_o  = res_hi;
    assign entrylo0_o = res_lo0;
    assign entrylo1_o = res_lo1;

endmodule
`default_nettype wire
